fifo_ctrl: RTL and testbench

//  Sequencing controller for the single-port-pair FIFO storage array (memory block).

---
 rtl/fifo_ctrl_if.sv | 59 +++++
 rtl/fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Purpose: user-side bus of the FIFO controller (request handshake, read data, status flags).
// Signals:
//   push/pop/flush/data_in          requests and write data from the user
//   data_out/rd_valid               read data and its qualifier back to the user
//   full/empty/almost_*/count       occupancy status
//   overflow/underflow              rejected-request pulses
// Modports: master = FIFO user logic, slave = fifo_ctrl.
interface fifo_ctrl_if #(
    parameter int unsigned D_WIDTH  = 4,
    parameter int unsigned A_HEIGHT = 4
) ();

    logic                push;
    logic                pop;
    logic                flush;
    logic [D_WIDTH-1:0]  data_in;
    logic [D_WIDTH-1:0]  data_out;
    logic                rd_valid;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic                almost_empty;
    logic [A_HEIGHT:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output push,
        output pop,
        output flush,
        output data_in,
        input  data_out,
        input  rd_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  push,
        input  pop,
        input  flush,
        input  data_in,
        output data_out,
        output rd_valid,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_ctrl.sv
// Purpose: sequencing controller for a FIFO built on an external 1-cycle-latency
//          storage array. Converts push/pop requests into memory write/read strobes
//          and pointers, tracks occupancy and produces status flags and error pulses.
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   bus (slave)         user-side requests, read data and status (see fifo_ctrl_if)
//   mem_write/mem_read  strobes to the storage array (combinational from accepted requests)
//   mem_wr_ptr/rd_ptr   registered write/read addresses to the storage array
//   mem_data_in         write data to the storage array (pass-through of data_in)
//   mem_data_out        read data from the storage array (returned as data_out)
module fifo_ctrl #(
    parameter int unsigned D_WIDTH  = 4,
    parameter int unsigned A_HEIGHT = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    fifo_ctrl_if.slave          bus,
    output logic                mem_write,
    output logic                mem_read,
    output logic [A_HEIGHT-1:0] mem_wr_ptr,
    output logic [A_HEIGHT-1:0] mem_rd_ptr,
    output logic [D_WIDTH-1:0]  mem_data_in,
    input  logic [D_WIDTH-1:0]  mem_data_out
);

    localparam int unsigned DEPTH = 1 << A_HEIGHT;
    localparam int unsigned CW    = A_HEIGHT + 1;

    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]       AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]       AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]       ONE_C   = CW'(1);
    localparam logic [A_HEIGHT-1:0] PTR_INC = A_HEIGHT'(1);

    // Registered state
    logic [A_HEIGHT-1:0] wr_ptr_q,    wr_ptr_d;
    logic [A_HEIGHT-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]       count_q,     count_d;
    logic                rd_valid_q,  rd_valid_d;
    logic                overflow_q,  overflow_d;
    logic                underflow_q, underflow_d;

    // Combinational request qualification and flags
    logic full_c;
    logic empty_c;
    logic push_acc;
    logic pop_acc;

    // Flags decode from the registered count only
    assign full_c   = (count_q == DEPTH_C);
    assign empty_c  = (count_q == '0);

    // Flush suppresses both requests; full/empty gate each side independently,
    // so a full FIFO still drains and an empty FIFO still fills on push+pop.
    assign push_acc = bus.push & ~full_c  & ~bus.flush;
    assign pop_acc  = bus.pop  & ~empty_c & ~bus.flush;

    // Next-state logic for pointers, occupancy and pulses
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = pop_acc;
        overflow_d  = bus.push & full_c  & ~bus.flush;
        underflow_d = bus.pop  & empty_c & ~bus.flush;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer width equals address width, so +1 wraps DEPTH-1 -> 0
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_INC;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_INC;
            end
            unique case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset wins over flush and requests
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory side
    assign mem_write   = push_acc;
    assign mem_read    = pop_acc;
    assign mem_wr_ptr  = wr_ptr_q;
    assign mem_rd_ptr  = rd_ptr_q;
    assign mem_data_in = bus.data_in;

    // User side
    assign bus.data_out     = mem_data_out;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a behavioural 1-cycle-latency memory closes the
// loop so data ordering is observable. Inputs change on the falling edge and outputs
// are compared 1 time unit later, i.e. they show the state left by the previous
// rising edge plus the combinational response to the current inputs.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] mem_wr_ptr;
    logic [3:0] mem_rd_ptr;
    logic [3:0] mem_data_in;
    logic [3:0] mem_data_out;

    int total;
    int bad;

    fifo_ctrl_if #(.D_WIDTH(4), .A_HEIGHT(4)) bus ();

    fifo_ctrl #(
        .D_WIDTH  (4),
        .A_HEIGHT (4),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_wr_ptr   (mem_wr_ptr),
        .mem_rd_ptr   (mem_rd_ptr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Storage array: write on edge, registered read
    logic [3:0] mem [16];
    always @(posedge clk) begin
        if (mem_write) mem[mem_wr_ptr] <= mem_data_in;
        if (mem_read)  mem_data_out    <= mem[mem_rd_ptr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic       rst;
        logic       push;
        logic       pop;
        logic       flush;
        logic [3:0] din;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       af;
        logic       ae;
        logic       rv;
        logic       ovf;
        logic       unf;
        logic       mw;
        logic       mr;
        logic [3:0] wp;
        logic [3:0] rp;
        logic [3:0] dout;
    } vec_t;

    function automatic vec_t mk(int chk, int r, int p, int q, int f, int d,
                                int c, int e, int fu, int af, int ae, int rv,
                                int ov, int un, int mw, int mr, int wp, int rp, int dout);
        vec_t v;
        v.chk   = 1'(chk);
        v.rst   = 1'(r);
        v.push  = 1'(p);
        v.pop   = 1'(q);
        v.flush = 1'(f);
        v.din   = 4'(d);
        v.count = 5'(c);
        v.empty = 1'(e);
        v.full  = 1'(fu);
        v.af    = 1'(af);
        v.ae    = 1'(ae);
        v.rv    = 1'(rv);
        v.ovf   = 1'(ov);
        v.unf   = 1'(un);
        v.mw    = 1'(mw);
        v.mr    = 1'(mr);
        v.wp    = 4'(wp);
        v.rp    = 4'(rp);
        v.dout  = 4'(dout);
        return v;
    endfunction

    task automatic drive(input logic r, input logic p, input logic q, input logic f,
                         input logic [3:0] d);
        @(negedge clk);
        rst         = r;
        bus.push    = p;
        bus.pop     = q;
        bus.flush   = f;
        bus.data_in = d;
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    vec_t       vq[$];
    logic [3:0] data [16];
    logic [3:0] din5 [16];

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = '0;

        // chk rst push pop flush din | count e f af ae rv ovf unf mw mr wp rp dout
        vq.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        vq.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        vq.push_back(mk(1, 0, 1, 0, 0, 10,  0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  0));
        vq.push_back(mk(1, 0, 1, 0, 0,  5,  1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0,  0));
        vq.push_back(mk(1, 0, 1, 0, 0,  6,  2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2, 0,  0));
        vq.push_back(mk(1, 0, 0, 1, 0,  0,  3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0));
        vq.push_back(mk(1, 0, 0, 1, 0,  0,  2, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3, 1, 10));
        vq.push_back(mk(1, 0, 0, 1, 0,  0,  1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3, 2,  5));
        vq.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 3, 3,  6));
        vq.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 3,  0));
        vq.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 3, 3,  0));
        vq.push_back(mk(1, 0, 1, 0, 1,  9,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 3,  0));
        vq.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));

        // Reset and basic push/pop/underflow/flush vectors
        foreach (vq[i]) begin
            logic [26:0] act;
            logic [26:0] exp;
            drive(vq[i].rst, vq[i].push, vq[i].pop, vq[i].flush, vq[i].din);
            if (vq[i].chk) begin
                act = {bus.count, bus.empty, bus.full, bus.almost_full, bus.almost_empty,
                       bus.rd_valid, bus.overflow, bus.underflow, mem_write, mem_read,
                       mem_wr_ptr, mem_rd_ptr, (vq[i].rv ? bus.data_out : 4'h0)};
                exp = {vq[i].count, vq[i].empty, vq[i].full, vq[i].af, vq[i].ae,
                       vq[i].rv, vq[i].ovf, vq[i].unf, vq[i].mw, vq[i].mr,
                       vq[i].wp, vq[i].rp, vq[i].dout};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL vec%0d: got %h expected %h", i, act, exp);
                end
            end
        end

        // Fill to full with threshold checks, then a rejected 17th push
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            data[i] = 4'(i * 7 + 3);
            drive(0, 1, 0, 0, data[i]);
            check("t3_wp", int'(mem_wr_ptr), i);
            check("t3_mw", int'(mem_write), 1);
            check("t3_af", int'(bus.almost_full), (i >= 12) ? 1 : 0);
            check("t3_ae", int'(bus.almost_empty), (i <= 2) ? 1 : 0);
            check("t3_full", int'(bus.full), 0);
        end
        drive(0, 0, 0, 0, 0);
        check("t3_full_set", int'(bus.full), 1);
        check("t3_count16", int'(bus.count), 16);
        check("t3_wp_wrap", int'(mem_wr_ptr), 0);
        drive(0, 1, 0, 0, 4'h5);
        check("t3_mw_rej", int'(mem_write), 0);
        drive(0, 0, 0, 0, 0);
        check("t3_ovf", int'(bus.overflow), 1);
        check("t3_count_hold", int'(bus.count), 16);

        // Full with push+pop: pop wins, push rejected
        drive(0, 1, 1, 0, 4'hE);
        check("t4_ovf_clr", int'(bus.overflow), 0);
        check("t4_mr", int'(mem_read), 1);
        check("t4_mw", int'(mem_write), 0);
        drive(0, 0, 0, 0, 0);
        check("t4_count15", int'(bus.count), 15);
        check("t4_ovf", int'(bus.overflow), 1);
        check("t4_rv", int'(bus.rd_valid), 1);
        check("t4_dout0", int'(bus.data_out), int'(data[0]));
        for (int k = 1; k < 16; k++) begin
            drive(0, 0, 1, 0, 0);
            check("t4_rp", int'(mem_rd_ptr), k);
            check("t4_mr_drain", int'(mem_read), 1);
            drive(0, 0, 0, 0, 0);
            check("t4_rv_drain", int'(bus.rd_valid), 1);
            check("t4_dout", int'(bus.data_out), int'(data[k]));
        end
        check("t4_empty", int'(bus.empty), 1);
        // Empty with push+pop: push wins, pop rejected
        drive(0, 1, 1, 0, 4'hB);
        check("t4_mw_e", int'(mem_write), 1);
        check("t4_mr_e", int'(mem_read), 0);
        drive(0, 0, 0, 0, 0);
        check("t4_count1", int'(bus.count), 1);
        check("t4_unf", int'(bus.underflow), 1);
        check("t4_rv_none", int'(bus.rd_valid), 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t4_rv_b", int'(bus.rd_valid), 1);
        check("t4_dout_b", int'(bus.data_out), 11);

        // Pointer wrap with data order preserved
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 4'(i + 1));
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            din5[i] = 4'(15 - i);
            drive(0, 1, 0, 0, din5[i]);
            check("t5_wp", int'(mem_wr_ptr), (3 + i) % 16);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 0, 0);
            check("t5_rp", int'(mem_rd_ptr), (3 + i) % 16);
            if (i > 0) check("t5_dout", int'(bus.data_out), int'(din5[i - 1]));
        end
        drive(0, 0, 0, 0, 0);
        check("t5_dout_last", int'(bus.data_out), int'(din5[15]));
        check("t5_empty", int'(bus.empty), 1);

        // Flush beats push; reset and flush both cancel a pending rd_valid
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 4'(i));
        drive(0, 0, 0, 0, 0);
        check("t6_count5", int'(bus.count), 5);
        drive(0, 1, 0, 1, 4'h7);
        check("t6_mw_flush", int'(mem_write), 0);
        drive(0, 0, 0, 0, 0);
        check("t6_count0", int'(bus.count), 0);
        check("t6_empty", int'(bus.empty), 1);
        check("t6_ptrs", int'({mem_wr_ptr, mem_rd_ptr}), 0);
        drive(0, 1, 0, 0, 4'h3);
        drive(0, 1, 0, 0, 4'h4);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t6_rv_rst", int'(bus.rd_valid), 0);
        check("t6_count_rst", int'(bus.count), 0);
        drive(0, 1, 0, 0, 4'h9);
        drive(0, 0, 1, 1, 0);
        check("t6_mr_flush", int'(mem_read), 0);
        drive(0, 0, 0, 0, 0);
        check("t6_rv_flush", int'(bus.rd_valid), 0);
        check("t6_unf_flush", int'(bus.underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
